// File: rtl/header_inserter_pkg.sv
// rtl/header_inserter_pkg.sv - shared types, sizes and mask helpers for the header inserter
package header_inserter_pkg;

    localparam int BEAT_BYTES             = 8;
    localparam int HDR_BYTES              = 6;
    localparam int packet_width_bits      = BEAT_BYTES * 8;
    localparam int byte_enable_width_bits = BEAT_BYTES;
    localparam int hdr_width_bits         = HDR_BYTES * 8;
    localparam int tail_bytes             = BEAT_BYTES - HDR_BYTES;
    localparam int tail_width_bits        = tail_bytes * 8;
    localparam int count_width_bits       = $clog2(BEAT_BYTES + 1);

    typedef logic [count_width_bits-1:0] byte_count_t;

    typedef struct packed {
        logic [15:0] header_a;
        logic [15:0] header_b;
        logic [15:0] header_c;
    } headers_t;

    typedef enum logic [1:0] {
        IDLE,
        BODY,
        FLUSH
    } inserter_state_t;

    // Which word the shift stage places in front of the payload tail bytes
    typedef enum logic [1:0] {
        SRC_HEADER,
        SRC_CARRY,
        SRC_FLUSH
    } shift_src_t;

    function automatic logic [byte_enable_width_bits-1:0] byte_mask(input byte_count_t count);
        logic [byte_enable_width_bits-1:0] m;
        m = '0;
        for (int i = 0; i < byte_enable_width_bits; i++) begin
            if (i < int'(count)) begin
                m[byte_enable_width_bits-1-i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic byte_count_t mask_popcount(input logic [byte_enable_width_bits-1:0] be);
        byte_count_t c;
        c = '0;
        for (int i = 0; i < byte_enable_width_bits; i++) begin
            c = c + byte_count_t'(be[i]);
        end
        return c;
    endfunction

    function automatic logic [packet_width_bits-1:0] expand_mask(input logic [byte_enable_width_bits-1:0] be);
        logic [packet_width_bits-1:0] m;
        for (int i = 0; i < byte_enable_width_bits; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/header_inserter_if.sv
// rtl/header_inserter_if.sv - header/payload input and wire-packet output bundle
interface header_inserter_if;
    import header_inserter_pkg::*;

    headers_t                          iHeaders;
    logic                              iPayload_valid;
    logic [packet_width_bits-1:0]      iPayload;
    logic                              iSop;
    logic                              iEop;
    logic [byte_enable_width_bits-1:0] iByte_enable;
    logic                              oReady;
    logic                              oValid;
    logic [packet_width_bits-1:0]      oPacket;
    logic                              oSop;
    logic                              oEop;
    logic [byte_enable_width_bits-1:0] oByte_enable;
    logic                              oError;

    modport master (
        output iHeaders, iPayload_valid, iPayload, iSop, iEop, iByte_enable,
        input  oReady, oValid, oPacket, oSop, oEop, oByte_enable, oError
    );

    modport slave (
        input  iHeaders, iPayload_valid, iPayload, iSop, iEop, iByte_enable,
        output oReady, oValid, oPacket, oSop, oEop, oByte_enable, oError
    );

endinterface

// File: rtl/header_inserter_shift.sv
// rtl/header_inserter_shift.sv - carry register and header/payload concatenation datapath
module header_shift_stage
    import header_inserter_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              carry_load,
    input  shift_src_t                        src,
    input  headers_t                          headers,
    input  logic [packet_width_bits-1:0]      payload,
    input  logic [byte_enable_width_bits-1:0] byte_enable,
    output logic [packet_width_bits-1:0]      beat
);

    logic [hdr_width_bits-1:0]    carry;
    logic [packet_width_bits-1:0] raw;

    // Low payload bytes spill into the next wire beat behind the header offset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry <= '0;
        end else if (carry_load) begin
            carry <= payload[hdr_width_bits-1:0];
        end
    end

    always_comb begin
        raw = '0;
        unique case (src)
            SRC_HEADER: raw = {headers, payload[packet_width_bits-1 -: tail_width_bits]};
            SRC_CARRY:  raw = {carry, payload[packet_width_bits-1 -: tail_width_bits]};
            SRC_FLUSH:  raw = {carry, {tail_width_bits{1'b0}}};
            default:    raw = '0;
        endcase
        beat = raw & expand_mask(byte_enable);
    end

endmodule

// File: rtl/header_inserter.sv
// rtl/header_inserter.sv - prepends a 6-byte header to a payload stream, one cycle latency
module header_inserter
    import header_inserter_pkg::*;
(
    input  logic              iClk,
    input  logic              iReset,
    header_inserter_if.slave  bus
);

    inserter_state_t                   state;
    inserter_state_t                   state_nxt;
    byte_count_t                       cbytes;
    byte_count_t                       cbytes_nxt;
    byte_count_t                       n;
    logic                              sop_collision;
    logic                              ready;
    logic                              accept;
    logic                              short_tail;
    logic                              tail_eop;
    logic [byte_enable_width_bits-1:0] beat_be;

    logic                              valid_d;
    logic                              sop_d;
    logic                              eop_d;
    logic                              err_d;
    logic [byte_enable_width_bits-1:0] be_d;
    logic                              carry_load;
    shift_src_t                        src;
    logic [packet_width_bits-1:0]      beat_d;

    // A new sop while a packet is open closes the old one first and is taken next cycle
    assign sop_collision = (state == BODY) && bus.iPayload_valid && bus.iSop;
    assign ready         = (state != FLUSH) && !sop_collision;
    assign accept        = bus.iPayload_valid && ready;
    assign bus.oReady    = ready;

    assign n          = mask_popcount(bus.iByte_enable);
    assign short_tail = n <= byte_count_t'(tail_bytes);
    assign tail_eop   = bus.iEop && short_tail;
    assign beat_be    = tail_eop ? byte_mask(byte_count_t'(HDR_BYTES) + n) : '1;

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            state  <= IDLE;
            cbytes <= '0;
        end else begin
            state  <= state_nxt;
            cbytes <= cbytes_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cbytes_nxt = cbytes;
        case (state)
            IDLE: begin
                if (accept && bus.iSop) begin
                    if (!bus.iEop) begin
                        state_nxt = BODY;
                    end else if (!short_tail) begin
                        state_nxt  = FLUSH;
                        cbytes_nxt = n - byte_count_t'(tail_bytes);
                    end
                end
            end
            BODY: begin
                if (sop_collision) begin
                    state_nxt = IDLE;
                end else if (accept && bus.iEop) begin
                    if (short_tail) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt  = FLUSH;
                        cbytes_nxt = n - byte_count_t'(tail_bytes);
                    end
                end
            end
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid_d    = 1'b0;
        sop_d      = 1'b0;
        eop_d      = 1'b0;
        err_d      = 1'b0;
        be_d       = '0;
        carry_load = 1'b0;
        src        = SRC_CARRY;
        case (state)
            IDLE: begin
                if (accept && bus.iSop) begin
                    valid_d    = 1'b1;
                    sop_d      = 1'b1;
                    eop_d      = tail_eop;
                    be_d       = beat_be;
                    carry_load = 1'b1;
                    src        = SRC_HEADER;
                end else if (accept) begin
                    err_d = 1'b1;
                end
            end
            BODY: begin
                if (sop_collision) begin
                    valid_d = 1'b1;
                    eop_d   = 1'b1;
                    err_d   = 1'b1;
                    be_d    = byte_mask(byte_count_t'(HDR_BYTES));
                    src     = SRC_FLUSH;
                end else if (accept) begin
                    valid_d    = 1'b1;
                    eop_d      = tail_eop;
                    be_d       = beat_be;
                    carry_load = 1'b1;
                    src        = SRC_CARRY;
                end
            end
            FLUSH: begin
                valid_d = 1'b1;
                eop_d   = 1'b1;
                be_d    = byte_mask(cbytes);
                src     = SRC_FLUSH;
            end
            default: ;
        endcase
    end

    header_shift_stage u_shift (
        .clk         (iClk),
        .rst_n       (iReset),
        .carry_load  (carry_load),
        .src         (src),
        .headers     (bus.iHeaders),
        .payload     (bus.iPayload),
        .byte_enable (be_d),
        .beat        (beat_d)
    );

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            bus.oValid       <= 1'b0;
            bus.oSop         <= 1'b0;
            bus.oEop         <= 1'b0;
            bus.oError       <= 1'b0;
            bus.oByte_enable <= '0;
            bus.oPacket      <= '0;
        end else begin
            bus.oValid       <= valid_d;
            bus.oSop         <= sop_d;
            bus.oEop         <= eop_d;
            bus.oError       <= err_d;
            bus.oByte_enable <= be_d;
            bus.oPacket      <= beat_d;
        end
    end

endmodule

// File: tb/tb_header_inserter.sv
// tb/tb_header_inserter.sv - directed self-checking bench for header_inserter
module tb_header_inserter;
    import header_inserter_pkg::*;

    logic iClk;
    logic iReset;
    int   checks;
    int   errors;

    header_inserter_if bus();

    header_inserter u_dut (
        .iClk   (iClk),
        .iReset (iReset),
        .bus    (bus)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // {valid, sop, eop, error, byte_enable, packet}
    logic [75:0] got;
    logic [75:0] exp;
    assign got = {bus.oValid, bus.oSop, bus.oEop, bus.oError, bus.oByte_enable, bus.oPacket};

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic e,
                         input logic [7:0] be, input logic [63:0] d);
        bus.iPayload_valid = v;
        bus.iSop           = s;
        bus.iEop           = e;
        bus.iByte_enable   = be;
        bus.iPayload       = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    endtask

    task automatic test_reset();
        iReset = 1'b0;
        bus.iHeaders = 48'hAAAA_BBBB_CCCC;
        idle();
        #12;
        exp = '0;
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_outputs got %h exp %h", got, exp); end
        tick();
        iReset = 1'b1;
        #1;
        checks++;
        if (bus.oReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.oReady); end
        tick();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_idle got %h exp %h", got, exp); end
    endtask

    task automatic test_single_beat();
        drive(1'b1, 1'b1, 1'b1, 8'hC0, 64'h1122_0000_0000_0000);
        #1;
        checks++;
        if (bus.oReady !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", bus.oReady); end
        tick();
        idle();
        exp = {4'b1110, 8'hFF, 64'hAAAA_BBBB_CCCC_1122};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL single_beat got %h exp %h", got, exp); end
        checks++;
        if (bus.oReady !== 1'b1) begin errors++; $display("FAIL single_ready_after got %b exp 1", bus.oReady); end
        tick();
        checks++;
        if (bus.oValid !== 1'b0) begin errors++; $display("FAIL single_quiet got %b exp 0", bus.oValid); end
    endtask

    task automatic test_two_beats();
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 64'h0102_0304_0506_0708);
        tick();
        drive(1'b1, 1'b0, 1'b1, 8'hC0, 64'h090A_0000_0000_0000);
        exp = {4'b1100, 8'hFF, 64'hAAAA_BBBB_CCCC_0102};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL two_first got %h exp %h", got, exp); end
        tick();
        idle();
        exp = {4'b1010, 8'hFF, 64'h0304_0506_0708_090A};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL two_last got %h exp %h", got, exp); end
        checks++;
        if (bus.oReady !== 1'b1) begin errors++; $display("FAIL two_no_flush got %b exp 1", bus.oReady); end
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 1'b1, 8'hE0, 64'h1122_33FF_FFFF_FFFF);
        tick();
        idle();
        exp = {4'b1100, 8'hFF, 64'hAAAA_BBBB_CCCC_1122};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL flush_first got %h exp %h", got, exp); end
        checks++;
        if (bus.oReady !== 1'b0) begin errors++; $display("FAIL flush_ready_low got %b exp 0", bus.oReady); end
        tick();
        exp = {4'b1010, 8'h80, 64'h3300_0000_0000_0000};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL flush_beat got %h exp %h", got, exp); end
        checks++;
        if (bus.oReady !== 1'b1) begin errors++; $display("FAIL flush_ready_back got %b exp 1", bus.oReady); end
        tick();
    endtask

    task automatic test_empty();
        drive(1'b1, 1'b1, 1'b1, 8'h00, 64'hDEAD_BEEF_CAFE_F00D);
        tick();
        idle();
        exp = {4'b1110, 8'hFC, 64'hAAAA_BBBB_CCCC_0000};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL empty_beat got %h exp %h", got, exp); end
        tick();
    endtask

    task automatic test_missing_eop();
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 64'h0102_0304_0506_0708);
        tick();
        drive(1'b1, 1'b1, 1'b1, 8'hC0, 64'h1122_0000_0000_0000);
        #1;
        checks++;
        if (bus.oReady !== 1'b0) begin errors++; $display("FAIL collide_ready got %b exp 0", bus.oReady); end
        tick();
        exp = {4'b1011, 8'hFC, 64'h0304_0506_0708_0000};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL collide_err_beat got %h exp %h", got, exp); end
        checks++;
        if (bus.oReady !== 1'b1) begin errors++; $display("FAIL collide_ready_back got %b exp 1", bus.oReady); end
        tick();
        idle();
        exp = {4'b1110, 8'hFF, 64'hAAAA_BBBB_CCCC_1122};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL collide_new_pkt got %h exp %h", got, exp); end
        tick();
    endtask

    task automatic test_drop_no_sop();
        drive(1'b1, 1'b0, 1'b0, 8'hFF, 64'h5555_5555_5555_5555);
        tick();
        idle();
        exp = {4'b0001, 8'h00, 64'h0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL drop_err got %h exp %h", got, exp); end
        tick();
        checks++;
        if (bus.oError !== 1'b0) begin errors++; $display("FAIL drop_err_pulse got %b exp 0", bus.oError); end
    endtask

    task automatic test_long_flush();
        bus.iHeaders = 48'h1234_5678_9ABC;
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 64'h1011_1213_1415_1617);
        tick();
        drive(1'b1, 1'b0, 1'b0, 8'hFF, 64'h1819_1A1B_1C1D_1E1F);
        exp = {4'b1100, 8'hFF, 64'h1234_5678_9ABC_1011};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL long_b0 got %h exp %h", got, exp); end
        tick();
        drive(1'b1, 1'b0, 1'b1, 8'hF0, 64'h2021_2223_0000_0000);
        exp = {4'b1000, 8'hFF, 64'h1213_1415_1617_1819};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL long_b1 got %h exp %h", got, exp); end
        tick();
        idle();
        exp = {4'b1000, 8'hFF, 64'h1A1B_1C1D_1E1F_2021};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL long_b2 got %h exp %h", got, exp); end
        tick();
        exp = {4'b1010, 8'hC0, 64'h2223_0000_0000_0000};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL long_flush got %h exp %h", got, exp); end
        bus.iHeaders = 48'hAAAA_BBBB_CCCC;
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 1'b1, 8'h80, 64'hAB00_0000_0000_0000);
        tick();
        drive(1'b1, 1'b1, 1'b1, 8'hC0, 64'h1122_0000_0000_0000);
        exp = {4'b1110, 8'hFE, 64'hAAAA_BBBB_CCCC_AB00};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL b2b_first got %h exp %h", got, exp); end
        checks++;
        if (bus.oReady !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", bus.oReady); end
        tick();
        idle();
        exp = {4'b1110, 8'hFF, 64'hAAAA_BBBB_CCCC_1122};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL b2b_second got %h exp %h", got, exp); end
        tick();
    endtask

    task automatic test_reset_mid_packet();
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 64'h0102_0304_0506_0708);
        tick();
        drive(1'b1, 1'b0, 1'b1, 8'hC0, 64'h090A_0000_0000_0000);
        #2;
        iReset = 1'b0;
        #1;
        exp = '0;
        checks++;
        if (got !== exp) begin errors++; $display("FAIL midreset_outputs got %h exp %h", got, exp); end
        tick();
        idle();
        iReset = 1'b1;
        tick();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL midreset_no_eop got %h exp %h", got, exp); end
        drive(1'b1, 1'b1, 1'b1, 8'hC0, 64'h1122_0000_0000_0000);
        tick();
        idle();
        exp = {4'b1110, 8'hFF, 64'hAAAA_BBBB_CCCC_1122};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL midreset_recover got %h exp %h", got, exp); end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_beat();
        test_two_beats();
        test_flush();
        test_empty();
        test_missing_eop();
        test_drop_no_sop();
        test_long_flush();
        test_back_to_back();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
